dmux_nway_reg: RTL and testbench

//   Registered, parametrised 1-to-N demultiplexer with valid/ready handshake. Generalises the

---
 rtl/dmux_nway_reg.sv | 93 +++++++++
 tb/tb_dmux_nway_reg.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dmux_nway_reg.sv
// Registered 1-to-N demultiplexer with valid/ready handshake, broadcast mode
// and out-of-range select detection (dropped words are counted, saturating).
module dmux_nway_reg #(
  parameter int unsigned N_CH   = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SEL_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  output logic [N_CH-1:0]          out_valid,
  input  logic [N_CH-1:0]          out_ready,
  output logic [N_CH*DATA_W-1:0]   out_data,
  output logic                     err,
  output logic [7:0]               drop_cnt
);

  logic [N_CH-1:0]        w_free;
  logic [N_CH-1:0]        w_sel_hot;
  logic [N_CH-1:0]        w_load;
  logic                   w_in_range;
  logic                   w_accept;
  logic                   w_drop;

  logic [N_CH-1:0]        r_valid;
  logic [N_CH*DATA_W-1:0] r_data;
  logic                   r_err;
  logic [7:0]             r_drop_cnt;

  // One-hot decode instead of indexing keeps out-of-range selects from
  // touching any channel when N_CH is not a power of two.
  always_comb begin
    w_free    = ~r_valid | out_ready;
    w_sel_hot = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      w_sel_hot[i] = (32'(in_sel) == i);
    end
    w_in_range = (32'(in_sel) < N_CH);

    if (in_bcast) begin
      in_ready = &w_free;
    end else if (w_in_range) begin
      in_ready = |(w_sel_hot & w_free);
    end else begin
      in_ready = 1'b1;
    end

    w_accept = in_valid & in_ready;
    w_load   = '0;
    if (w_accept) begin
      w_load = in_bcast ? '1 : w_sel_hot;
    end
    w_drop = w_accept & ~in_bcast & ~w_in_range;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_data  <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (w_load[i]) begin
          r_valid[i]                   <= 1'b1;
          r_data[i*DATA_W +: DATA_W]   <= in_data;
        end else if (out_ready[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_err <= w_drop;
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign err       = r_err;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_dmux_nway_reg.sv
// Randomized bench for dmux_nway_reg: 8-channel instance against a behavioural
// model, plus a 6-channel instance for out-of-range drop counting.
module tb_dmux_nway_reg;
  localparam int N = 8;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             in_valid, in_ready, in_bcast;
  logic [W-1:0]     in_data;
  logic [2:0]       in_sel;
  logic [N-1:0]     out_valid, out_ready;
  logic [N*W-1:0]   out_data;
  logic             err;
  logic [7:0]       drop_cnt;

  logic             v6, rdy6, bc6, err6;
  logic [W-1:0]     d6;
  logic [2:0]       sel6;
  logic [5:0]       ov6, or6;
  logic [6*W-1:0]   od6;
  logic [7:0]       cnt6;

  dmux_nway_reg #(.N_CH(8), .DATA_W(8), .SEL_W(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err(err), .drop_cnt(drop_cnt)
  );

  dmux_nway_reg #(.N_CH(6), .DATA_W(8), .SEL_W(3)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(v6), .in_ready(rdy6),
    .in_data(d6), .in_sel(sel6), .in_bcast(bc6),
    .out_valid(ov6), .out_ready(or6), .out_data(od6),
    .err(err6), .drop_cnt(cnt6)
  );

  int n_tot = 0;
  int n_bad = 0;

  // Model state: one buffer per channel plus the drop counter.
  logic       mv [N];
  logic [7:0] md [N];
  int         mcnt;
  logic       merr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tot++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 1'b0;
      md[i] = '0;
    end
    mcnt = 0;
    merr = 1'b0;
  endtask

  function automatic logic model_ready();
    logic r;
    if (in_bcast) begin
      r = 1'b1;
      for (int i = 0; i < N; i++) if (mv[i] && !out_ready[i]) r = 1'b0;
    end else if (int'(in_sel) < N) begin
      r = !mv[in_sel] || out_ready[in_sel];
    end else begin
      r = 1'b1;
    end
    return r;
  endfunction

  task automatic model_step(input logic acc);
    merr = acc && !in_bcast && (int'(in_sel) >= N);
    if (merr && mcnt < 255) mcnt++;
    for (int i = 0; i < N; i++) begin
      if (acc && (in_bcast || int'(in_sel) == i)) begin
        mv[i] = 1'b1;
        md[i] = in_data;
      end else if (out_ready[i]) begin
        mv[i] = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0]   ev;
    logic [N*W-1:0] ed;
    for (int i = 0; i < N; i++) begin
      ev[i]        = mv[i];
      ed[i*W +: W] = md[i];
    end
    check("out_valid", 64'(out_valid), 64'(ev));
    check("out_data",  64'(out_data),  64'(ed));
    check("err",       64'(err),       64'(merr));
    check("drop_cnt",  64'(drop_cnt),  64'(mcnt));
  endtask

  // Starts just after a rising edge; drives, checks ready, clocks, checks outputs.
  task automatic cycle(input logic v, input logic [2:0] s, input logic b,
                       input logic [7:0] d, input logic [N-1:0] r);
    logic exp_rdy;
    in_valid  = v;
    in_sel    = s;
    in_bcast  = b;
    in_data   = d;
    out_ready = r;
    #1;
    exp_rdy = model_ready();
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    model_step(v & exp_rdy);
    #1;
    check_outputs();
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_sel = '0; in_bcast = 1'b0; in_data = '0; out_ready = '0;
    v6 = 1'b0; sel6 = '0; bc6 = 1'b0; d6 = '0; or6 = '0;
    model_reset();

    // Reset state and ready for every select.
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    for (int s = 0; s < N; s++) begin
      in_sel = 3'(s);
      #1 check("rst_ready", 64'(in_ready), 64'd1);
    end
    in_bcast = 1'b1;
    #1 check("rst_ready_bc", 64'(in_ready), 64'd1);
    in_bcast = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Unicast sweep, consumers always ready.
    for (int s = 0; s < N; s++) begin
      cycle(1'b1, 3'(s), 1'b0, 8'hA0 + 8'(s), 8'hFF);
      check("uni_valid", 64'(out_valid), 64'd1 << s);
      check("uni_data", 64'(out_data[s*W +: W]), 64'(8'hA0 + 8'(s)));
    end
    cycle(1'b0, 3'd0, 1'b0, 8'h00, 8'hFF);

    // Backpressure on channel 3, then load-and-drain in one cycle.
    cycle(1'b1, 3'd3, 1'b0, 8'h11, 8'h00);
    cycle(1'b1, 3'd3, 1'b0, 8'h22, 8'h00);
    check("bp_hold", 64'(out_data[3*W +: W]), 64'h11);
    cycle(1'b1, 3'd3, 1'b0, 8'h22, 8'h08);
    check("thru_valid", 64'(out_valid[3]), 64'd1);
    check("thru_data", 64'(out_data[3*W +: W]), 64'h22);
    cycle(1'b0, 3'd0, 1'b0, 8'h00, 8'hFF);

    // Broadcast, then broadcast blocked by a full channel 6.
    cycle(1'b1, 3'd0, 1'b1, 8'h5A, 8'hFF);
    check("bc_valid", 64'(out_valid), 64'hFF);
    cycle(1'b0, 3'd0, 1'b0, 8'h00, 8'hFF);
    cycle(1'b1, 3'd6, 1'b0, 8'h77, 8'h00);
    cycle(1'b1, 3'd0, 1'b1, 8'h99, 8'hBF);
    check("bc_blocked", 64'(out_valid), 64'h40);
    check("bc_ch6", 64'(out_data[6*W +: W]), 64'h77);
    cycle(1'b0, 3'd0, 1'b0, 8'h00, 8'hFF);

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      cycle(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 7) == 0), 8'($urandom),
            8'($urandom) | 8'($urandom));
    end

    // Asynchronous reset with channels 1 and 4 full.
    cycle(1'b1, 3'd1, 1'b0, 8'hC1, 8'h00);
    cycle(1'b1, 3'd4, 1'b0, 8'hC4, 8'h00);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_data", 64'(out_data), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();

    // Out-of-range drops on the 6-channel build.
    v6 = 1'b1; sel6 = 3'd7; bc6 = 1'b0; d6 = 8'h3C; or6 = '0;
    for (int k = 1; k <= 300; k++) begin
      check("oor_ready", 64'(rdy6), 64'd1);
      @(posedge clk);
      #1;
      check("oor_err", 64'(err6), 64'd1);
      check("oor_cnt", 64'(cnt6), 64'(k < 255 ? k : 255));
      check("oor_valid", 64'(ov6), 64'd0);
    end
    v6 = 1'b0;
    @(posedge clk);
    #1;
    check("oor_err_off", 64'(err6), 64'd0);
    check("oor_cnt_hold", 64'(cnt6), 64'd255);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
